// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and widths
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_FIX  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one shift-add step of the sequential multiplier
module mul_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;

  // Add the multiplicand into the high half when the current multiplier bit
  // is set, keep the carry, then shift the whole accumulator right by one.
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? mcand_i : '0)};
    acc_o = (2*WIDTH)'({sum, acc_i[WIDTH-1:0]} >> 1);
  end

endmodule

// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - multi-cycle shift-add multiplier with valid/ready handshakes
module mul16_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_signed,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_t         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               accept;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc)
  );

  // Handshake outputs; abort holds off a new operation in the same cycle.
  always_comb begin
    start_ready = (state_q == MUL_IDLE) && !abort;
    accept      = start_valid && start_ready;
    res_valid   = (state_q == MUL_DONE);
    busy        = (state_q != MUL_IDLE);
    res_hi      = acc_q[2*WIDTH-1:WIDTH];
    res_lo      = acc_q[WIDTH-1:0];
  end

  // Operand magnitudes; negating the most negative value wraps to its unsigned magnitude.
  always_comb begin
    a_mag = (op_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    b_mag = (op_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
  end

  // Sequencer: accept, WIDTH add/shift steps, optional sign fix, then hold result.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    unique case (state_q)
      MUL_IDLE: begin
        if (accept) begin
          neg_d   = op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          mcand_d = a_mag;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          count_d = '0;
          state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        acc_d   = step_acc;
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = MUL_FIX;
        end
      end
      MUL_FIX: begin
        if (neg_q) begin
          acc_d = ~acc_q + 1'b1;
        end
        state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (res_ready) begin
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
    if (abort && (state_q != MUL_IDLE)) begin
      state_d = MUL_IDLE;
    end
  end

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
    end
  end

endmodule
